// File: rtl/div_issue.sv
// EX-stage divide issue controller: launches a multi-cycle divide, stalls EX until
// the divider is ready, writes HI/LO for one cycle and drains the divider on flush.
module div_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic        r_signed;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_accept;
    logic        w_result;

    assign w_accept = (r_state == S_IDLE) && ex_div_valid_i && !flush_i;
    // Flush wins over a simultaneous ready: the result of a killed divide is dropped.
    assign w_result = (r_state == S_BUSY) && !flush_i && div_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_signed <= 1'b0;
            r_op1    <= 32'd0;
            r_op2    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_BUSY && flush_i)
                r_cnt <= 2'd0;
            else if (r_state == S_DRAIN)
                r_cnt <= r_cnt + 2'd1;
            if (w_accept) begin
                r_signed <= ex_signed_i;
                r_op1    <= ex_op1_i;
                r_op2    <= ex_op2_i;
            end
            if (w_result) begin
                r_hi <= div_result_i[63:32];
                r_lo <= div_result_i[31:0];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_BUSY;
            S_BUSY: begin
                if (flush_i)          w_next = S_DRAIN;
                else if (div_ready_i) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            // Two cycles of stop+annul frees the divider from any of its states.
            S_DRAIN: if (r_cnt == 2'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        div_start_o = (r_state == S_BUSY);
        div_annul_o = (r_state == S_DRAIN);
        whilo_o     = (r_state == S_DONE) && !flush_i;
        stallreq_o  = !flush_i && (((r_state == S_IDLE) && ex_div_valid_i) ||
                                   (r_state == S_BUSY) ||
                                   ((r_state == S_DRAIN) && ex_div_valid_i));
    end

    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: behavioural divider model, table of divides plus flush/reset
// sequences, HI/LO checked through a scoreboard queue popped on whilo_o.
module tb_div_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_signed_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        flush_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    div_issue dut (
        .clk(clk), .rst(rst),
        .ex_div_valid_i(ex_div_valid_i), .ex_signed_i(ex_signed_i),
        .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i), .flush_i(flush_i),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Divider model: ready after 35 cycles of start (3 for a zero divisor), held until stop.
    logic [5:0] d_cnt;
    always @(posedge clk) begin
        if (rst || !div_start_o) d_cnt <= 6'd0;
        else if (d_cnt != 6'd63) d_cnt <= d_cnt + 6'd1;
    end
    assign div_ready_i = div_start_o && (d_cnt >= ((div_op2_o == 32'd0) ? 6'd3 : 6'd35));

    always_comb begin
        logic signed [31:0] sa, sb;
        sa = div_op1_o;
        sb = div_op2_o;
        div_result_i = 64'd0;
        if (div_op2_o != 32'd0) begin
            if (div_signed_o) div_result_i = {32'(sa % sb), 32'(sa / sb)};
            else              div_result_i = {div_op1_o % div_op2_o, div_op1_o / div_op2_o};
        end
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endfunction

    typedef struct { logic [31:0] hi; logic [31:0] lo; } res_t;
    res_t sb_q[$];

    always @(negedge clk) begin
        if (!rst && whilo_o) begin
            if (sb_q.size() == 0) chk("unexpected_whilo", 1, 0);
            else begin
                res_t e;
                e = sb_q.pop_front();
                chk("hi", hi_o, e.hi);
                chk("lo", lo_o, e.lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output int acc);
        tick();
        ex_div_valid_i = 1'b1;
        ex_signed_i    = sg;
        ex_op1_i       = a;
        ex_op2_i       = b;
        acc            = cycle;
        #1;
        chk("stall_at_accept", stallreq_o, 1);
        chk("start_at_accept", div_start_o, 0);
    endtask

    task automatic wait_done(input logic sg, input logic [31:0] a, input logic [31:0] b,
                             input int acc, input int lat, output int done);
        bit got = 0;
        done = 0;
        for (int k = 1; k <= 60 && !got; k++) begin
            tick();
            #1;
            if (whilo_o) begin
                got  = 1;
                done = cycle;
                chk("latency", 96'(cycle - acc), 96'(lat));
                chk("stall_done", stallreq_o, 0);
                chk("start_done", div_start_o, 0);
                ex_div_valid_i = 1'b0;
            end else begin
                chk("stall_busy", stallreq_o, 1);
                chk("start_busy", div_start_o, 1);
                chk("ops_stable", {div_signed_o, div_op1_o, div_op2_o}, {sg, a, b});
            end
        end
        if (!got) chk("timeout_whilo", 0, 1);
    endtask

    typedef struct {
        logic        sg;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;
    vec_t vt[6];

    initial begin
        int acc, done, prev_done;
        vt[0] = '{1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 37};
        vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 37};
        vt[2] = '{1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 5};
        vt[3] = '{1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5};
        vt[4] = '{1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 37};
        vt[5] = '{1'b0, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 37};

        rst = 1'b1; ex_div_valid_i = 1'b0; ex_signed_i = 1'b0;
        ex_op1_i = 32'd0; ex_op2_i = 32'd0; flush_i = 1'b0;
        repeat (3) tick();
        #1;
        chk("reset_outs", {div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o,
                           div_op1_o, div_op2_o}, 0);
        chk("reset_hilo", {hi_o, lo_o}, 0);
        rst = 1'b0;

        // Table: consecutive entries are issued back-to-back.
        prev_done = 0;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{vt[i].hi, vt[i].lo});
            issue(vt[i].sg, vt[i].a, vt[i].b, acc);
            if (i > 0) chk("b2b_accept", 96'(acc - prev_done), 96'd1);
            wait_done(vt[i].sg, vt[i].a, vt[i].b, acc, vt[i].lat, done);
            prev_done = done;
        end

        // Flush at A+10, then DIVU 9/3 offered during DRAIN.
        issue(1'b0, 32'd100, 32'd7, acc);
        repeat (9) tick();
        tick();
        flush_i = 1'b1;
        #1;
        chk("stall_flush", stallreq_o, 0);
        tick();
        flush_i = 1'b0;
        ex_op1_i = 32'd9; ex_op2_i = 32'd3; ex_signed_i = 1'b0;
        sb_q.push_back('{32'd0, 32'd3});
        #1;
        chk("drain1", {div_annul_o, div_start_o, stallreq_o}, 3'b101);
        tick();
        #1;
        chk("drain2", {div_annul_o, div_start_o, stallreq_o}, 3'b101);
        tick();
        acc = cycle;
        #1;
        chk("drain_over", {div_annul_o, div_start_o, stallreq_o}, 3'b001);
        wait_done(1'b0, 32'd9, 32'd3, acc, 37, done);

        // Flush during DONE suppresses the HI/LO write.
        issue(1'b0, 32'd8, 32'd0, acc);
        repeat (4) tick();
        tick();
        flush_i = 1'b1;
        #1;
        chk("flush_done_whilo", whilo_o, 0);
        ex_div_valid_i = 1'b0;
        tick();
        flush_i = 1'b0;
        #1;
        chk("after_flush_done", {div_start_o, div_annul_o, stallreq_o, whilo_o}, 0);

        // Reset mid-BUSY, then a normal divide.
        issue(1'b1, 32'd1000, 32'd3, acc);
        repeat (10) tick();
        rst = 1'b1;
        ex_div_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_busy_outs", {div_start_o, div_annul_o, div_signed_o, stallreq_o, whilo_o,
                              div_op1_o, div_op2_o}, 0);
        chk("rst_busy_hilo", {hi_o, lo_o}, 0);
        sb_q.push_back('{32'd1, 32'd33});
        issue(1'b0, 32'd100, 32'd3, acc);
        wait_done(1'b0, 32'd100, 32'd3, acc, 37, done);

        tick();
        tick();
        chk("scoreboard_empty", 96'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
